spi_init_sequencer: RTL
=======================

// Module: spi_init_sequencer
// PURPOSE
// Program sequencer for the SPI display link. Fetches 10-bit instructions from a sync ROM:
// opcodes 00 = write data, 01 = write command, 10 = delay, 11 = end. Bytes are serialised
// MSB-first, paced by the serialClock strobes; cs, dc and delays are driven per opcode.
// Sits between the init/frame ROM and the display pins; replaces hand-driven instr stimulus.
// PARAMETERS
// ADDR_W      8     ROM address width; program space 2**ADDR_W words
// DELAY_UNIT  1000  clk cycles per delay count (delay = payload * DELAY_UNIT)
// PORTS
// clk          in   1       system clock; all state on posedge
// reset        in   1       asynchronous, active-high; all state cleared immediately
// start        in   1       run program from address 0; sampled only in IDLE
// sclkPosEdge  in   1       1-cycle strobe, serial clock rising edge (display samples)
// sclkNegEdge  in   1       1-cycle strobe, serial clock falling edge (mosi changes)
// romAddr      out  ADDR_W  instruction address to ROM
// romData      in   10      ROM word, valid 1 clk after romAddr (sync read)
// cs           out  1       display chip select, active low
// dc           out  1       1 = data, 0 = command; valid whenever cs = 0
// mosi         out  1       serial data, MSB first
// busy         out  1       high from start accept until return to IDLE
// done         out  1       1-cycle pulse, program finished
// overrun      out  1       sticky: ran off program end without opcode 11; cleared by start
// BEHAVIOUR
// - Reset values: romAddr=0, cs=1, dc=1, mosi=0, busy=0, done=0, overrun=0, state IDLE.
// - Reset mid-operation: outputs return to reset values at once; partial byte abandoned.
// - States: IDLE, FETCH, DECODE, SHIFT, DELAY, DONE. All outputs registered.
// - IDLE: start=1 -> romAddr=0, overrun=0, busy=1, go FETCH. start while busy ignored.
// - FETCH: one wait cycle for ROM latency -> DECODE.
// - DECODE: latch romData; op = [9:8], payload = [7:0].
//   00/01: shreg=payload, mosi=payload[7], dc = (op==00), cs=0, bitcnt=0 -> SHIFT.
//   10: cs=1; payload==0 -> advance immediately (no DELAY cycle); else
//       cnt = payload*DELAY_UNIT-1 -> DELAY.
//   11: cs=1 -> DONE.
// - SHIFT: on sclkPosEdge bitcnt++. On sclkNegEdge with bitcnt>0 and bitcnt<8:
//   shreg<<=1, mosi=next bit. Strobes before the first posedge are ignored.
//   After 8th posedge -> advance. cs held low.
// - DELAY: cnt decrements each clk; at cnt==0 -> advance. Total in DELAY =
//   payload*DELAY_UNIT cycles; strobes ignored.
// - advance: if romAddr == 2**ADDR_W-1 -> overrun=1, cs=1, DONE;
//   else romAddr++, FETCH.
// - cs stays low across consecutive 00/01 words (no deassert between bytes);
//   dc may change between bytes while cs low (updated in DECODE, before the next
//   first posedge).
// - DONE: done=1 for one cycle, busy=0, -> IDLE (cs=1).
// - Delay counter width: ceil(log2(255*DELAY_UNIT+1)); no saturation needed.
// - Simultaneous sclkPosEdge and sclkNegEdge on one clk: never produced by serialClock;
//   if seen, posedge is processed first.
// TESTING
// 1. ROM {01_2A, 00_55, 11_00}, start pulse -> cs low for 16 posedges; mosi =
//    0x2A with dc=0, then 0x55 with dc=1; done pulse; overrun=0.
// 2. ROM {10_03, 11_00}, DELAY_UNIT=4 -> cs=1 throughout; 12 clks in DELAY;
//    done pulse; mosi never toggles.
// 3. ROM {10_00, 00_FF, 11_00} -> zero delay skipped; byte 0xFF shifted; done.
// 4. Reset asserted after 3rd posedge of byte 0xA5 -> cs=1, busy=0 same cycle;
//    new start replays from address 0 with full byte.
// 5. ADDR_W=2, ROM all 00_00, no end opcode -> 4 bytes sent, overrun=1, done
//    pulse, romAddr holds 3; next start clears overrun.
// 6. start held high throughout run -> exactly one program run per IDLE entry;
//    start during SHIFT has no effect on romAddr.

Source files
------------

// File: rtl/spi_init_sequencer.sv
// spi_init_sequencer
// Runs a small program stored in a synchronous ROM and drives the SPI display pins.
// Each 10-bit instruction word is {op[1:0], payload[7:0]}:
//   00 = send payload as a data byte (dc=1)
//   01 = send payload as a command byte (dc=0)
//   10 = wait payload*DELAY_UNIT clk cycles (a payload of 0 costs no wait)
//   11 = end of program
// Bytes go out MSB first. mosi changes only on sclkNegEdge strobes, and bits are
// counted on sclkPosEdge strobes. Both strobes come from an external serial clock
// generator.
//
// Ports
//   clk          system clock; all state changes on its rising edge
//   reset        asynchronous, active-high; returns every output to idle values
//   start        starts the program at address 0; only looked at while idle
//   sclkPosEdge  1-cycle strobe marking a serial clock rising edge
//   sclkNegEdge  1-cycle strobe marking a serial clock falling edge
//   romAddr      instruction address to the ROM
//   romData      ROM word, valid one clk after romAddr
//   cs           display chip select, active low
//   dc           1 = data, 0 = command
//   mosi         serial data out
//   busy         high while a program is running
//   done         1-cycle pulse when a program finishes
//   overrun      sticky flag: the program ran past the last address with no end opcode
module spi_init_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int DELAY_UNIT = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sclkPosEdge,
  input  logic              sclkNegEdge,
  output logic [ADDR_W-1:0] romAddr,
  input  logic [9:0]        romData,
  output logic              cs,
  output logic              dc,
  output logic              mosi,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int                CNT_W     = $clog2(255 * DELAY_UNIT + 1);
  localparam logic [CNT_W-1:0]  UNIT_C    = CNT_W'(DELAY_UNIT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    SHIFT,
    DELAY,
    DONE
  } state_t;

  state_t            state_reg;
  logic [7:0]        shreg_reg;
  logic [3:0]        bitcnt_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic [1:0]        op;
  logic [7:0]        payload;
  logic              advance;

  // romData is the word addressed by romAddr, because FETCH waited one cycle for it
  assign op      = romData[9:8];
  assign payload = romData[7:0];

  // These are the three ways an instruction can finish and move to the next address.
  // A byte finishes on its 8th posedge strobe, when bitcnt is still 7.
  assign advance = ((state_reg == SHIFT)  && sclkPosEdge && (bitcnt_reg == 4'd7)) ||
                   ((state_reg == DELAY)  && (cnt_reg == '0)) ||
                   ((state_reg == DECODE) && (op == 2'b10) && (payload == 8'd0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      romAddr    <= '0;
      cs         <= 1'b1;
      dc         <= 1'b1;
      mosi       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      shreg_reg  <= '0;
      bitcnt_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            romAddr   <= '0;
            overrun   <= 1'b0;
            busy      <= 1'b1;
            state_reg <= FETCH;
          end
        end
        FETCH: state_reg <= DECODE;
        DECODE: begin
          case (op)
            2'b00, 2'b01: begin
              // cs may already be low from the previous byte; it stays low
              shreg_reg  <= payload;
              mosi       <= payload[7];
              dc         <= (op == 2'b00);
              cs         <= 1'b0;
              bitcnt_reg <= '0;
              state_reg  <= SHIFT;
            end
            2'b10: begin
              // For a zero payload, the advance logic below overrides this next state
              cs        <= 1'b1;
              cnt_reg   <= CNT_W'(payload) * UNIT_C - CNT_W'(1);
              state_reg <= DELAY;
            end
            default: begin
              cs        <= 1'b1;
              state_reg <= DONE;
            end
          endcase
        end
        SHIFT: begin
          // A posedge strobe takes priority. Before the first posedge (bitcnt==0),
          // negedge strobes are ignored, so bit 7 stays on mosi until it is sampled.
          if (sclkPosEdge) begin
            bitcnt_reg <= bitcnt_reg + 4'd1;
          end else if (sclkNegEdge && (bitcnt_reg != 4'd0) && (bitcnt_reg < 4'd8)) begin
            shreg_reg <= {shreg_reg[6:0], 1'b0};
            mosi      <= shreg_reg[6];
          end
        end
        DELAY: cnt_reg <= cnt_reg - CNT_W'(1);
        DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          cs        <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      if (advance) begin
        if (romAddr == LAST_ADDR) begin
          // The program ran past the end without an end opcode
          overrun   <= 1'b1;
          cs        <= 1'b1;
          state_reg <= DONE;
        end else begin
          romAddr   <= romAddr + ADDR_W'(1);
          state_reg <= FETCH;
        end
      end
    end
  end

endmodule
